// File: rtl/display_scan_mux_pkg.sv
// Shared constants, types and helpers for the four-digit display scanner.
// Imported by display_scan_mux and refresh_prescaler.
package display_scan_mux_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SLOT_W     = 2;
    localparam int DIGIT_W    = 4;
    localparam int FRAME_W    = NUM_DIGITS * DIGIT_W;
    localparam int PRE_W      = 16;

    localparam logic [NUM_DIGITS-1:0] AN_BLANK = 4'b1111;

    typedef logic [SLOT_W-1:0]     slot_t;
    typedef logic [DIGIT_W-1:0]    digit_t;
    typedef logic [NUM_DIGITS-1:0] an_t;
    typedef logic [FRAME_W-1:0]    frame_t;
    typedef logic [PRE_W-1:0]      pre_t;

    // Nibble k of a four-digit frame, digit 0 in the low bits.
    function automatic digit_t nibble_of(frame_t f, slot_t k);
        return f[k*DIGIT_W +: DIGIT_W];
    endfunction

    // True when digit k and every digit to its left are zero.
    // A-F nibbles are non-zero bit patterns, so they keep a digit lit.
    function automatic logic upper_zero(frame_t f, slot_t k);
        frame_t shifted;
        shifted = f >> (int'(k) * DIGIT_W);
        return (shifted == '0);
    endfunction

    // Active-low one-hot anode pattern for slot k.
    function automatic an_t anode_of(slot_t k);
        an_t a;
        a    = AN_BLANK;
        a[k] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/display_scan_mux_refresh_prescaler.sv
// Refresh prescaler: free-running 0..REFRESH_DIV-1 counter, frozen when idle.
// Ports: clk, rst (sync, active-high), enable, tick (last count while enabled).
module refresh_prescaler
    import display_scan_mux_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam pre_t LAST = pre_t'(REFRESH_DIV - 1);

    pre_t count;
    logic at_last;

    assign at_last = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (enable) begin
            count <= at_last ? '0 : count + pre_t'(1);
        end
    end

    // Combinational so the slot advances on the same edge the count wraps.
    assign tick = enable && at_last;

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit multiplexed display scanner with double-buffered digits,
// leading-zero blanking and a frame pulse.
// Ports: clk, rst (sync, active-high), enable, load, digits_in[15:0],
//        blank_lz -> digit_out[3:0], an_out[3:0] (active-low), frame_tick.
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        blank_lz,
    output logic [3:0]  digit_out,
    output logic [3:0]  an_out,
    output logic        frame_tick
);

    logic   tick;
    logic   boundary;
    slot_t  slot;
    frame_t pending;
    frame_t pending_next;
    logic   pending_valid;
    logic   valid_next;
    frame_t active;
    frame_t active_next;
    an_t    lit;

    refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    assign boundary = tick && (slot == slot_t'(NUM_DIGITS - 1));

    // Buffer update. A load landing on the boundary edge bypasses pending
    // so it is visible from the very next frame's slot 0.
    always_comb begin
        pending_next = pending;
        valid_next   = pending_valid;
        active_next  = active;
        if (boundary) begin
            if (load) begin
                active_next = digits_in;
            end else if (pending_valid) begin
                active_next = pending;
            end
            valid_next = 1'b0;
        end else if (load) begin
            pending_next = digits_in;
            valid_next   = 1'b1;
        end
    end

    // Anode pattern for the current slot; digit 0 is never suppressed.
    always_comb begin
        lit = anode_of(slot);
        if (blank_lz && (slot != '0) && upper_zero(active, slot)) begin
            lit = AN_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot          <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            active        <= '0;
            digit_out     <= '0;
            an_out        <= AN_BLANK;
            frame_tick    <= 1'b0;
        end else begin
            if (tick) begin
                slot <= slot + slot_t'(1);
            end
            pending       <= pending_next;
            pending_valid <= valid_next;
            active        <= active_next;
            frame_tick    <= boundary;
            // Outputs sample slot/active before this edge's update.
            if (enable) begin
                digit_out <= nibble_of(active, slot);
                an_out    <= lit;
            end else begin
                an_out    <= AN_BLANK;
            end
        end
    end

endmodule
